// File: rtl/shiftx_pkg.sv
// Shared definitions for the shiftx scan controller and its slice extractor:
// FSM state encoding, default widths and the taint-join helper.
package shiftx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_A_WIDTH   = 32;
  localparam int DEF_Y_WIDTH   = 8;
  localparam int DEF_B_WIDTH   = 6;
  localparam int DEF_CNT_WIDTH = 4;
  localparam int DEF_T_WIDTH   = 32;

  // Labels up to this width can be joined; callers zero-extend and truncate.
  localparam int TAINT_MAX = 64;

  function automatic logic [TAINT_MAX-1:0] taint_join(
    input logic [TAINT_MAX-1:0] lhs,
    input logic [TAINT_MAX-1:0] rhs
  );
    return lhs | rhs;
  endfunction

endpackage

// File: rtl/shiftx_slice.sv
// Pure combinational zero-filling extractor: y[i] = a[off+i] when in range,
// else 0; the label joins the data taint and the offset taint.
module shiftx_slice
  import shiftx_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int Y_WIDTH = DEF_Y_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int T_WIDTH = DEF_T_WIDTH
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [T_WIDTH-1:0] a_t,
  input  logic [B_WIDTH-1:0] off,
  input  logic [T_WIDTH-1:0] off_t,
  output logic [Y_WIDTH-1:0] y,
  output logic [T_WIDTH-1:0] y_t
);

  // A logical right shift never wraps the offset and shifts in zeros, which
  // is exactly the zero fill for bit positions at or beyond A_WIDTH.
  always_comb begin
    y   = Y_WIDTH'(a >> off);
    y_t = T_WIDTH'(taint_join(TAINT_MAX'(a_t), TAINT_MAX'(off_t)));
  end

endmodule

// File: rtl/shiftx_scan_ctrl.sv
// Scan controller: captures a data word plus (start, stride, count) command and
// emits count tainted slices through a valid/ready output port.
module shiftx_scan_ctrl
  import shiftx_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int Y_WIDTH   = DEF_Y_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int T_WIDTH   = DEF_T_WIDTH
) (
  input  logic                 CLK,
  input  logic                 ARST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [T_WIDTH-1:0]   A_t,
  input  logic [B_WIDTH-1:0]   START,
  input  logic [B_WIDTH-1:0]   STRIDE,
  input  logic [CNT_WIDTH-1:0] COUNT,
  input  logic [T_WIDTH-1:0]   CMD_t,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Y_WIDTH-1:0]   Y,
  output logic [T_WIDTH-1:0]   Y_t,
  output logic                 out_last,
  output logic                 busy,
  output logic                 state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready may depend on out_ready/abort combinationally; out_* never
  // depend on in_* combinationally. abort in RUN cancels the presented slice
  // and also blocks a command from being taken on the last-slice cycle.

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   a_q;
  logic [T_WIDTH-1:0]   a_t_q;
  logic [T_WIDTH-1:0]   cmd_t_q;
  logic [B_WIDTH-1:0]   stride_q;
  logic [B_WIDTH-1:0]   off_q;
  logic [CNT_WIDTH-1:0] rem_q;

  logic                 is_last;
  logic                 accept;
  logic                 slice_xfer;
  logic [Y_WIDTH-1:0]   y_raw;
  logic [T_WIDTH-1:0]   y_t_raw;

  assign is_last    = (rem_q == CNT_WIDTH'(1));
  assign accept     = in_valid && in_ready;
  assign slice_xfer = (state_q == RUN) && out_ready && !abort;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = out_ready && is_last && !abort;
      default: in_ready = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (COUNT != '0)) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready && is_last) begin
          state_d = (in_valid && (COUNT != '0)) ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new command overrides the counter step on a back-to-back last handshake.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      a_q      <= '0;
      a_t_q    <= '0;
      cmd_t_q  <= '0;
      stride_q <= '0;
      off_q    <= '0;
      rem_q    <= '0;
    end else if (accept) begin
      a_q      <= A;
      a_t_q    <= A_t;
      cmd_t_q  <= CMD_t;
      stride_q <= STRIDE;
      off_q    <= START;
      rem_q    <= COUNT;
    end else if (slice_xfer) begin
      off_q    <= off_q + stride_q;
      rem_q    <= rem_q - CNT_WIDTH'(1);
    end
  end

  shiftx_slice #(
    .A_WIDTH (A_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .B_WIDTH (B_WIDTH),
    .T_WIDTH (T_WIDTH)
  ) u_slice (
    .a     (a_q),
    .a_t   (a_t_q),
    .off   (off_q),
    .off_t (cmd_t_q),
    .y     (y_raw),
    .y_t   (y_t_raw)
  );

  // Output logic: everything is forced to zero outside RUN.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    Y         = '0;
    Y_t       = '0;
    if (state_q == RUN) begin
      out_valid = 1'b1;
      out_last  = is_last;
      busy      = 1'b1;
      Y         = y_raw;
      Y_t       = y_t_raw;
    end
  end

  assign state_dbg = state_q;

endmodule
